// File: rtl/image_bram_reader.sv
// image_bram_reader
// Streams a complete frame out of the image BRAM in raster order (address 0
// to IMAGE_SIZE-1) into the output image FIFO. A 2-entry skid buffer absorbs
// the 1-cycle BRAM read latency. A read is issued only when a buffer slot is
// guaranteed, so FIFO backpressure never drops or duplicates a pixel.
//
// Optional build macro: LANE_OVERLAY_EN. When defined, a 1-bit lane mask
// BRAM is read in lockstep with the image BRAM. Masked pixels are replaced
// with LANE_COLOR as they are pushed into the skid buffer.
//
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   start          begin frame readout (sampled only in IDLE)
//   busy           high whenever the FSM is not IDLE
//   done           one-cycle pulse in the first IDLE cycle after the last write
//   bram_rd_en     image BRAM read strobe (combinational)
//   bram_rd_addr   image BRAM read address
//   bram_rd_data   image BRAM data, valid 1 cycle after bram_rd_en
//   lane_rd_*      lane mask BRAM read port (LANE_OVERLAY_EN only)
//   out_wr_en      output FIFO write (combinational)
//   out_full       output FIFO full
//   out_din        output FIFO data (0 when out_wr_en is low)
//
// FIFO handshake: a pixel transfers in any cycle where out_wr_en=1. The
// block raises out_wr_en only when it holds a pixel and out_full=0, so the
// write is never retracted and needs no acknowledgement.
module image_bram_reader #(
    parameter int          WIDTH      = 1280,
    parameter int          HEIGHT     = 720,
    parameter int          IMAGE_SIZE = WIDTH * HEIGHT,
    parameter logic [23:0] LANE_COLOR = 24'hFF0000,
    localparam int         AW         = $clog2(IMAGE_SIZE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          bram_rd_en,
    output logic [AW-1:0] bram_rd_addr,
    input  logic [23:0]   bram_rd_data,
`ifdef LANE_OVERLAY_EN
    output logic          lane_rd_en,
    output logic [AW-1:0] lane_rd_addr,
    input  logic          lane_rd_data,
`endif
    output logic          out_wr_en,
    input  logic          out_full,
    output logic [23:0]   out_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);

    state_t        state;
    logic [AW-1:0] addr_cnt;
    logic          inflight;      // a read issued last cycle returns data now
    logic [1:0]    occ;           // skid buffer occupancy, 0..2
    logic [23:0]   buf_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic          done_r;

    logic          issue;
    logic          push;
    logic          pop;
    logic [2:0]    credit_used;
    logic [1:0]    occ_next;
    logic [23:0]   push_data;

`ifdef LANE_OVERLAY_EN
    assign push_data = lane_rd_data ? LANE_COLOR : bram_rd_data;
    assign lane_rd_en   = bram_rd_en;
    assign lane_rd_addr = bram_rd_addr;
`else
    logic [23:0] unused_lane_color;
    assign unused_lane_color = LANE_COLOR;
    assign push_data = bram_rd_data;
`endif

    always_comb begin
        push        = inflight;
        pop         = !reset && (occ != 2'd0) && !out_full;
        // Slots already spoken for: data in the buffer plus data on its way
        // from the BRAM, less the slot freed by this cycle's write.
        credit_used = {2'b00, inflight} + {1'b0, occ} - {2'b00, pop};
        issue       = !reset && (state == READ) && (credit_used < 3'd2);
        occ_next    = 2'(occ + {1'b0, push} - {1'b0, pop});
    end

    // All outputs are forced low while reset is asserted.
    assign bram_rd_en   = issue;
    assign bram_rd_addr = reset ? '0 : addr_cnt;
    assign out_wr_en    = pop;
    assign out_din      = pop ? buf_mem[rd_ptr] : 24'd0;
    assign busy         = !reset && (state != IDLE);
    assign done         = !reset && done_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            addr_cnt <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            inflight <= issue;
            occ      <= occ_next;
            done_r   <= 1'b0;
            if (push) begin
                buf_mem[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        addr_cnt <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        // The counter parks on the last address; it never wraps.
                        if (addr_cnt == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // No reads are issued here, so inflight drops next cycle.
                    // Leave as soon as the buffer will be empty, so done lands
                    // in the cycle right after the final write.
                    if (occ_next == 2'd0) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_bram_reader.sv
// Testbench for image_bram_reader with a small 4x2 frame.
// The BRAM holds k*0x000101 at address k. A table of frame scenarios sets the
// out_full patterns. A reference model derives the expected behaviour from
// pixel counts and cycle numbers. Hand-written sequences cover the reset
// and restart corner cases.
`timescale 1ns/1ps
module tb_image_bram_reader;

    localparam int          WIDTH      = 4;
    localparam int          HEIGHT     = 2;
    localparam int          IMAGE_SIZE = WIDTH * HEIGHT;
    localparam int          AW         = $clog2(IMAGE_SIZE);
    localparam logic [23:0] LANE_COLOR = 24'hFF0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          bram_rd_en;
    logic [AW-1:0] bram_rd_addr;
    logic [23:0]   bram_rd_data;
    logic          out_wr_en;
    logic          out_full;
    logic [23:0]   out_din;
`ifdef LANE_OVERLAY_EN
    logic          lane_rd_en;
    logic [AW-1:0] lane_rd_addr;
    logic          lane_rd_data;
    logic          lane_mask [IMAGE_SIZE];
`endif

    logic [23:0] bram [IMAGE_SIZE];
    logic [23:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int mode;         // 0 free-running, 1 full in cycles 2..11, 2 toggling, 3 random
        int restart_cyc;  // cycle of an extra start pulse while busy, -1 for none
        int exp_first;    // expected cycle of first write, -1 when not fixed
        int exp_done;     // expected cycle of done, -1 when not fixed
    } vec_t;

    vec_t tbl [6];

    image_bram_reader #(
        .WIDTH      (WIDTH),
        .HEIGHT     (HEIGHT),
        .LANE_COLOR (LANE_COLOR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .bram_rd_en   (bram_rd_en),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_data (bram_rd_data),
`ifdef LANE_OVERLAY_EN
        .lane_rd_en   (lane_rd_en),
        .lane_rd_addr (lane_rd_addr),
        .lane_rd_data (lane_rd_data),
`endif
        .out_wr_en    (out_wr_en),
        .out_full     (out_full),
        .out_din      (out_din)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // Synchronous-read memory models: data valid the cycle after the strobe.
    always @(posedge clock) begin
        if (bram_rd_en) bram_rd_data <= bram[bram_rd_addr];
`ifdef LANE_OVERLAY_EN
        if (lane_rd_en) lane_rd_data <= lane_mask[lane_rd_addr];
`endif
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] exp_pixel(input int k);
`ifdef LANE_OVERLAY_EN
        if (lane_mask[k]) return LANE_COLOR;
`endif
        return bram[k];
    endfunction

    function automatic logic full_for(input int mode, input int c);
        case (mode)
            1:       return (c >= 2) && (c <= 11);
            2:       return (c % 2) == 1;
            3:       return $urandom_range(0, 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic fill_expected();
        exp_q.delete();
        for (int k = 0; k < IMAGE_SIZE; k++) exp_q.push_back(exp_pixel(k));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, bram_rd_en, 0);
        check({tag, "_rd_addr"}, bram_rd_addr, 0);
        check({tag, "_wr_en"}, out_wr_en, 0);
        check({tag, "_din"}, out_din, 0);
    endtask

    // ---------------- one frame against the reference model ----------------
    // Inputs change 1ns after the rising edge; outputs are sampled on the
    // falling edge. Cycle 0 is the cycle in which start is held high.
    task automatic run_frame(input vec_t v);
        int  issued = 0;
        int  issued_prev = 0;
        int  issued_prev2 = 0;
        int  writes = 0;
        int  first_wr = -1;
        int  done_cyc = -1;
        bit  finished = 0;
        logic exp_busy;
        logic exp_done;
        fill_expected();
        for (int c = 0; c < 300 && !finished; c++) begin
            @(posedge clock);
            #1;
            start    = (c == 0) || (c == v.restart_cyc);
            out_full = full_for(v.mode, c);
            @(negedge clock);
            // Frame is busy from cycle 1 until the cycle after the last write.
            exp_done = (writes == IMAGE_SIZE);
            exp_busy = (c >= 1) && !exp_done;
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            // Buffered pixels: returned by the BRAM (issued 2+ cycles ago) minus written.
            check("occupancy_le2", (issued_prev2 - writes) <= 2, 1);
            if (out_wr_en) begin
                check("wr_while_full", out_full, 0);
                check("no_extra_write", writes < IMAGE_SIZE, 1);
                if (exp_q.size() > 0) check($sformatf("pixel%0d", writes), out_din, exp_q.pop_front());
                if (first_wr < 0) first_wr = c;
                writes++;
            end else begin
                check("din_idle_zero", out_din, 0);
            end
            if (bram_rd_en) begin
                check("rd_addr_order", bram_rd_addr, issued);
                issued++;
            end
            check("read_ahead_le2", (issued - writes) <= 2, 1);
`ifdef LANE_OVERLAY_EN
            check("lane_rd_en", lane_rd_en, bram_rd_en);
            if (bram_rd_en) check("lane_rd_addr", lane_rd_addr, bram_rd_addr);
`endif
            if (exp_done) begin
                finished = 1;
                done_cyc = c;
            end
            issued_prev2 = issued_prev;
            issued_prev  = issued;
        end
        check("frame_finished", finished, 1);
        check("write_total", writes, IMAGE_SIZE);
        check("read_total", issued, IMAGE_SIZE);
        if (v.exp_first >= 0) check("first_write_cycle", first_wr, v.exp_first);
        if (v.exp_done >= 0) check("done_cycle", done_cyc, v.exp_done);
        // Quiet afterwards: no second frame, no second done.
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            start    = 0;
            out_full = 0;
            @(negedge clock);
            check("post_busy", busy, 0);
            check("post_done", done, 0);
            check("post_rd_en", bram_rd_en, 0);
            check("post_wr_en", out_wr_en, 0);
        end
    endtask

    // ---------------- reset in the middle of a frame ----------------
    task automatic reset_mid_frame();
        int writes = 0;
        bit fired = 0;
        fill_expected();
        for (int c = 0; c < 40 && !fired; c++) begin
            @(posedge clock);
            #1;
            start    = (c == 0);
            out_full = 0;
            if (writes == 3) begin
                reset = 1;
                fired = 1;
            end
            @(negedge clock);
            if (out_wr_en) begin
                if (exp_q.size() > 0) check($sformatf("pre_reset_pixel%0d", writes), out_din, exp_q.pop_front());
                writes++;
            end
        end
        check("reset_fired", fired, 1);
        @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
        check_outputs_zero("after_mid_reset");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < IMAGE_SIZE; k++) bram[k] = 24'(24'h000100 * k + k);
`ifdef LANE_OVERLAY_EN
        for (int k = 0; k < IMAGE_SIZE; k++) lane_mask[k] = (k == 2) || (k == 5);
`endif
        bram_rd_data = '0;
        tbl[0] = '{0, -1, 3, 11};
        tbl[1] = '{1, -1, 12, 20};
        tbl[2] = '{2, -1, -1, -1};
        tbl[3] = '{0, 5, 3, 11};
        tbl[4] = '{3, -1, -1, -1};
        tbl[5] = '{3, -1, -1, -1};

        reset    = 1;
        start    = 0;
        out_full = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_outputs_zero("in_reset");
        @(posedge clock);
        #1;
        reset = 0;
        @(negedge clock);
        check_outputs_zero("after_reset");

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        reset_mid_frame();
        run_frame(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
